// File: rtl/bus_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module  : bus_arbiter_rr
// Brief   : Round-robin shared-bus arbiter with phase tracking, watchdog
//           reclaim and saturating timeout / protocol-violation counters.
// Revision: 1.0 - initial release
// ============================================================================
module bus_arbiter_rr #(
    parameter int DeviceMaxNumber = 4,
    parameter int TimeoutCycles   = 16
) (
    input  logic                       clk,
    input  logic                       clrn,
    input  logic [DeviceMaxNumber-1:0] BARQ,
    output logic [DeviceMaxNumber-1:0] BAGD,
    input  logic                       AddressValid,
    input  logic                       TargetReady,
    input  logic                       DataStrobe,
    output logic [1:0][7:0]            Error
);

    localparam int                c_pw      = (DeviceMaxNumber > 1) ? $clog2(DeviceMaxNumber) : 1;
    localparam logic [c_pw-1:0]   c_ptr_rst = c_pw'(DeviceMaxNumber - 1);
    localparam logic [7:0]        c_wd_last = 8'(TimeoutCycles - 1);
    localparam logic [7:0]        c_sat     = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GRANT = 3'd1,
        S_ADDR  = 3'd2,
        S_DATA  = 3'd3,
        S_TURN  = 3'd4
    } state_t;

    state_t                      r_state;
    state_t                      w_next_state;
    logic [DeviceMaxNumber-1:0]  r_req;
    logic [DeviceMaxNumber-1:0]  r_bagd;
    logic [DeviceMaxNumber-1:0]  w_next_bagd;
    logic [c_pw-1:0]             r_ptr;
    logic [c_pw-1:0]             w_next_ptr;
    logic [7:0]                  r_wdog;
    logic [7:0]                  w_next_wdog;
    logic [7:0]                  r_err_to;
    logic [7:0]                  r_err_pv;
    logic [c_pw-1:0]             w_winner;
    logic                        w_found;
    logic                        w_owner_req;
    logic                        w_wd_expire;
    logic                        w_timeout;
    logic                        w_viol;

    assign w_owner_req = BARQ[r_ptr];
    assign w_wd_expire = (r_wdog == c_wd_last);

    // Scan starts one past the last winner so every requester gets a turn.
    always_comb begin
        int j;
        logic [c_pw-1:0] w_idx;
        w_found  = 1'b0;
        w_winner = r_ptr;
        for (int i = 1; i <= DeviceMaxNumber; i++) begin
            j = int'(r_ptr) + i;
            if (j >= DeviceMaxNumber) begin
                j = j - DeviceMaxNumber;
            end
            w_idx = c_pw'(j);
            if (!w_found && r_req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_bagd  = r_bagd;
        w_next_ptr   = r_ptr;
        w_next_wdog  = r_wdog;
        w_timeout    = 1'b0;
        w_viol       = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_viol = AddressValid | DataStrobe;
                if (w_found) begin
                    w_next_bagd           = '0;
                    w_next_bagd[w_winner] = 1'b1;
                    w_next_ptr            = w_winner;
                    w_next_state          = S_GRANT;
                end
            end
            S_GRANT: begin
                w_viol = DataStrobe | TargetReady;
                if (!w_owner_req) begin
                    w_next_state = S_TURN;
                end else if (AddressValid) begin
                    w_next_state = S_ADDR;
                end else if (w_wd_expire) begin
                    w_timeout    = 1'b1;
                    w_next_state = S_TURN;
                end else begin
                    w_next_wdog = r_wdog + 8'd1;
                end
            end
            S_ADDR: begin
                w_viol = DataStrobe;
                if (!w_owner_req) begin
                    w_next_state = S_TURN;
                end else if (TargetReady) begin
                    w_next_state = S_DATA;
                end else if (w_wd_expire) begin
                    w_timeout    = 1'b1;
                    w_next_state = S_TURN;
                end else begin
                    w_next_wdog = r_wdog + 8'd1;
                end
            end
            S_DATA: begin
                if (!w_owner_req) begin
                    w_next_state = S_TURN;
                end else if (DataStrobe) begin
                    w_next_wdog = 8'd0;
                end else if (w_wd_expire) begin
                    w_timeout    = 1'b1;
                    w_next_state = S_TURN;
                end else begin
                    w_next_wdog = r_wdog + 8'd1;
                end
            end
            S_TURN: begin
                w_viol       = AddressValid | DataStrobe;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_bagd  = '0;
            end
        endcase

        // Any phase change restarts the idle count; turnaround always frees the bus.
        if (w_next_state != r_state) begin
            w_next_wdog = 8'd0;
        end
        if (w_next_state == S_TURN) begin
            w_next_bagd = '0;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state  <= S_IDLE;
            r_req    <= '0;
            r_bagd   <= '0;
            r_ptr    <= c_ptr_rst;
            r_wdog   <= 8'd0;
            r_err_to <= 8'd0;
            r_err_pv <= 8'd0;
        end else begin
            r_state <= w_next_state;
            r_req   <= BARQ;
            r_bagd  <= w_next_bagd;
            r_ptr   <= w_next_ptr;
            r_wdog  <= w_next_wdog;
            if (w_timeout && (r_err_to != c_sat)) begin
                r_err_to <= r_err_to + 8'd1;
            end
            if (w_viol && (r_err_pv != c_sat)) begin
                r_err_pv <= r_err_pv + 8'd1;
            end
        end
    end

    assign BAGD  = r_bagd;
    assign Error = {r_err_pv, r_err_to};

endmodule
`default_nettype wire
